// File: rtl/usb_in_ep_engine_if.sv
// usb_in_ep_engine_if: packet-layer PID/byte stream between the USB framing layer and the IN engine
interface usb_in_ep_engine_if;
  logic [3:0] rx_pid;
  logic rx_pid_valid;
  logic [7:0] rx_data;
  logic rx_data_valid;
  logic rx_pkt_start;
  logic rx_pkt_end;
  logic rx_crc_err;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  logic tx_data_valid;
  logic tx_pkt_start;
  logic tx_pkt_end;
  logic tx_ready;
  modport master(
    output rx_pid, rx_pid_valid, rx_data, rx_data_valid, rx_pkt_start, rx_pkt_end, rx_crc_err, tx_ready,
    input tx_pid, tx_data, tx_data_valid, tx_pkt_start, tx_pkt_end
  );
  modport slave(
    input rx_pid, rx_pid_valid, rx_data, rx_data_valid, rx_pkt_start, rx_pkt_end, rx_crc_err, tx_ready,
    output tx_pid, tx_data, tx_data_valid, tx_pkt_start, tx_pkt_end
  );
endinterface

// File: rtl/usb_in_ep_engine.sv
// usb_in_ep_engine: interrupt IN endpoint engine with per-EP retransmit buffers, toggles, STALL, SOF and EP0 forwarding
module usb_in_ep_engine #(
  parameter int NUM_EP = 2,
  parameter int MAX_PKT = 8,
  parameter int TIMEOUT_CYC = 96
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          dev_addr,
  usb_in_ep_engine_if.slave   pk,
  input  logic [NUM_EP*8-1:0] ep_wr_data,
  input  logic [NUM_EP-1:0]   ep_wr_valid,
  input  logic [NUM_EP-1:0]   ep_wr_last,
  output logic [NUM_EP-1:0]   ep_wr_ready,
  input  logic [NUM_EP-1:0]   ep_halt,
  input  logic [NUM_EP-1:0]   ep_toggle_clr,
  output logic [NUM_EP-1:0]   ep_sent,
  output logic                ep0_token,
  output logic [3:0]          ep0_pid,
  output logic [10:0]         frame_num,
  output logic                sof_pulse,
  output logic                busy
);
  localparam int EW = NUM_EP > 1 ? $clog2(NUM_EP) : 1;
  localparam int AW = MAX_PKT > 1 ? $clog2(MAX_PKT) : 1;
  localparam int PW = $clog2(MAX_PKT + 1);
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [3:0] P_IN = 4'b1001, P_SOF = 4'b0101, P_ACK = 4'b0010, P_NAK = 4'b1010;
  localparam logic [3:0] P_STALL = 4'b1110, P_DATA0 = 4'b0011, P_DATA1 = 4'b1011;
  typedef enum logic [2:0] {IDLE, TOKEN, TX_HDR, TX_DATA, TX_END, WAIT_HS} state_t;
  state_t state, nxt;
  logic [3:0] rxp, cur_pid, pid_q, resp_pid, endp;
  logic [1:0] bcnt;
  logic [7:0] b0;
  logic [2:0] b1;
  logic tok_ok, hit, in_ok, in_q, ack_ev, tmo, resp_data;
  logic [EW-1:0] ep_sel;
  logic [PW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [NUM_EP-1:0] tog, full;
  logic [PW-1:0] len_a [NUM_EP];
  logic [7:0] rd [NUM_EP];
  // PID may arrive in the same cycle as rx_pkt_end, so prefer the live strobe
  assign cur_pid = pk.rx_pid_valid ? pk.rx_pid : rxp;
  assign endp = {b1, b0[7]};
  assign tok_ok = state == TOKEN && pk.rx_pkt_end && !pk.rx_crc_err && bcnt == 2'd2 && cur_pid[1:0] == 2'b01;
  assign hit = tok_ok && cur_pid != P_SOF && b0[6:0] == dev_addr;
  assign in_ok = hit && cur_pid == P_IN && endp != 4'd0 && endp <= 4'(NUM_EP);
  assign ack_ev = state == WAIT_HS && pk.rx_pkt_end && !pk.rx_crc_err && cur_pid == P_ACK;
  assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
  assign resp_data = full[ep_sel] && !ep_halt[ep_sel];
  assign resp_pid = ep_halt[ep_sel] ? P_STALL : !full[ep_sel] ? P_NAK : tog[ep_sel] ? P_DATA1 : P_DATA0;
  assign pk.tx_pid = state == TX_HDR ? resp_pid : pid_q;
  assign pk.tx_data = state == TX_DATA ? rd[ep_sel] : 8'd0;
  assign busy = state != IDLE;
  assign ep_wr_ready = ~full;
  always_comb begin
    nxt = state;
    pk.tx_pkt_start = 1'b0;
    pk.tx_data_valid = 1'b0;
    pk.tx_pkt_end = 1'b0;
    case (state)
      IDLE: nxt = pk.rx_pkt_start ? TOKEN : IDLE;
      TOKEN: nxt = in_q ? TX_HDR : (pk.rx_pkt_end && !in_ok) ? IDLE : TOKEN;
      TX_HDR: begin
        pk.tx_pkt_start = 1'b1;
        nxt = resp_data ? TX_DATA : TX_END;
      end
      TX_DATA: begin
        pk.tx_data_valid = pk.tx_ready;
        nxt = (pk.tx_ready && idx == len_a[ep_sel] - PW'(1)) ? TX_END : TX_DATA;
      end
      TX_END: begin
        pk.tx_pkt_end = pk.tx_ready;
        nxt = !pk.tx_ready ? TX_END : pid_q[1:0] == 2'b11 ? WAIT_HS : IDLE;
      end
      WAIT_HS: nxt = (pk.rx_pkt_end || tmo) ? IDLE : WAIT_HS;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rxp <= '0;
      bcnt <= '0;
      b0 <= '0;
      b1 <= '0;
      in_q <= 1'b0;
      ep_sel <= '0;
      frame_num <= '0;
      sof_pulse <= 1'b0;
      ep0_token <= 1'b0;
      ep0_pid <= '0;
      pid_q <= '0;
      idx <= '0;
      cnt <= '0;
      tog <= '0;
      ep_sent <= '0;
    end else begin
      state <= nxt;
      rxp <= pk.rx_pid_valid ? pk.rx_pid : pk.rx_pkt_start ? 4'd0 : rxp;
      bcnt <= pk.rx_pkt_start ? 2'd0 : (pk.rx_data_valid && bcnt != 2'd3) ? bcnt + 2'd1 : bcnt;
      if (pk.rx_data_valid && bcnt == 2'd0) b0 <= pk.rx_data;
      if (pk.rx_data_valid && bcnt == 2'd1) b1 <= pk.rx_data[2:0];
      in_q <= in_ok;
      if (in_ok) ep_sel <= EW'(endp - 4'd1);
      sof_pulse <= tok_ok && cur_pid == P_SOF;
      if (tok_ok && cur_pid == P_SOF) frame_num <= {b1, b0};
      ep0_token <= hit && endp == 4'd0;
      if (hit && endp == 4'd0) ep0_pid <= cur_pid;
      if (state == TX_HDR) pid_q <= resp_pid;
      idx <= state != TX_DATA ? '0 : pk.tx_ready ? idx + PW'(1) : idx;
      cnt <= state != WAIT_HS ? '0 : cnt + CW'(1);
      tog <= ~ep_toggle_clr & (ack_ev ? tog ^ (NUM_EP'(1) << ep_sel) : tog);
      ep_sent <= ack_ev ? NUM_EP'(1) << ep_sel : '0;
    end
  end
  // buffer release waits for ep_sent so ep_wr_ready rises one cycle after it
  for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
    logic [7:0] mem [MAX_PKT];
    logic [PW-1:0] ptr, len;
    logic f;
    always_ff @(posedge clk) begin
      if (rst) begin
        ptr <= '0;
        len <= '0;
        f <= 1'b0;
      end else if (ep_sent[i]) begin
        ptr <= '0;
        f <= 1'b0;
      end else if (ep_wr_valid[i] && !f) begin
        mem[ptr[AW-1:0]] <= ep_wr_data[8*i +: 8];
        ptr <= ptr + PW'(1);
        if (ep_wr_last[i] || ptr == PW'(MAX_PKT - 1)) begin
          f <= 1'b1;
          len <= ptr + PW'(1);
        end
      end
    end
    assign full[i] = f;
    assign len_a[i] = len;
    assign rd[i] = mem[idx[AW-1:0]];
  end
endmodule

// File: tb/tb_usb_in_ep_engine.sv
// tb_usb_in_ep_engine: directed scenario tests for the IN endpoint engine with hand-computed expectations
module tb_usb_in_ep_engine;
  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SOF = 4'b0101, P_SETUP = 4'b1101;
  localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_STALL = 4'b1110;
  localparam logic [3:0] P_DATA0 = 4'b0011, P_DATA1 = 4'b1011;
  localparam logic [6:0] ADDR = 7'h2A;
  logic clk = 1'b0;
  logic rst;
  logic [6:0] dev_addr;
  logic [15:0] ep_wr_data;
  logic [1:0] ep_wr_valid, ep_wr_last, ep_wr_ready, ep_halt, ep_toggle_clr, ep_sent;
  logic ep0_token, sof_pulse, busy;
  logic [3:0] ep0_pid;
  logic [10:0] frame_num;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] cap_pid, end_pid;
  int cap_n, st_t, viol, w;
  logic got_end;
  logic [63:0] capv;
  usb_in_ep_engine_if pk();
  usb_in_ep_engine #(.NUM_EP(2), .MAX_PKT(8), .TIMEOUT_CYC(96)) dut (
    .clk(clk), .rst(rst), .dev_addr(dev_addr), .pk(pk),
    .ep_wr_data(ep_wr_data), .ep_wr_valid(ep_wr_valid), .ep_wr_last(ep_wr_last), .ep_wr_ready(ep_wr_ready),
    .ep_halt(ep_halt), .ep_toggle_clr(ep_toggle_clr), .ep_sent(ep_sent),
    .ep0_token(ep0_token), .ep0_pid(ep0_pid), .frame_num(frame_num), .sof_pulse(sof_pulse), .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [3:0] pid, input logic [7:0] d0, input logic [7:0] d1, input int n,
                          input logic crc, input logic [1:0] clr);
    pk.rx_pkt_start = 1'b1;
    tick();
    pk.rx_pkt_start = 1'b0;
    pk.rx_pid = pid;
    pk.rx_pid_valid = 1'b1;
    tick();
    pk.rx_pid_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      pk.rx_data = i == 0 ? d0 : d1;
      pk.rx_data_valid = 1'b1;
      tick();
    end
    pk.rx_data_valid = 1'b0;
    pk.rx_pkt_end = 1'b1;
    pk.rx_crc_err = crc;
    ep_toggle_clr = clr;
    tick();
    pk.rx_pkt_end = 1'b0;
    pk.rx_crc_err = 1'b0;
    ep_toggle_clr = 2'b00;
  endtask

  task automatic send_tok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
    send_raw(pid, {ep[0], addr}, {5'd0, ep[3:1]}, 2, 1'b0, 2'b00);
  endtask

  task automatic load(input int ep, input int n, input logic [7:0] first, input logic last);
    for (int i = 0; i < n; i++) begin
      ep_wr_data = '0;
      ep_wr_data[8*ep +: 8] = first + 8'(i);
      ep_wr_valid = 2'b00;
      ep_wr_valid[ep] = 1'b1;
      ep_wr_last = 2'b00;
      ep_wr_last[ep] = last && i == n - 1;
      tick();
    end
    ep_wr_valid = 2'b00;
    ep_wr_last = 2'b00;
  endtask

  task automatic get_pkt(input logic stall);
    cap_pid = 4'hF;
    end_pid = 4'hF;
    cap_n = 0;
    st_t = -1;
    viol = 0;
    got_end = 1'b0;
    capv = '0;
    for (int t = 0; t < 60 && !got_end; t++) begin
      pk.tx_ready = stall ? t[0] : 1'b1;
      #1;
      if (pk.tx_pkt_start) begin
        cap_pid = pk.tx_pid;
        st_t = t;
      end
      if (pk.tx_data_valid) begin
        capv = {capv[55:0], pk.tx_data};
        cap_n++;
      end
      if (pk.tx_pkt_end) begin
        end_pid = pk.tx_pid;
        got_end = 1'b1;
      end
      if ((pk.tx_data_valid && !pk.tx_ready) || int'(pk.tx_pkt_start) + int'(pk.tx_pkt_end) + int'(pk.tx_data_valid) > 1) viol++;
      tick();
    end
    pk.tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if ({ep_wr_ready, busy, ep_sent, sof_pulse, ep0_token} !== {2'b11, 1'b0, 2'b00, 1'b0, 1'b0})
      begin n_bad++; $display("FAIL reset_ctrl got %b want 1100000", {ep_wr_ready, busy, ep_sent, sof_pulse, ep0_token}); end
    n_cmp++; if ({pk.tx_pkt_start, pk.tx_data_valid, pk.tx_pkt_end, pk.tx_pid, pk.tx_data} !== 15'd0)
      begin n_bad++; $display("FAIL reset_tx got %h want 0", {pk.tx_pkt_start, pk.tx_data_valid, pk.tx_pkt_end, pk.tx_pid, pk.tx_data}); end
    n_cmp++; if ({frame_num, ep0_pid} !== 15'd0) begin n_bad++; $display("FAIL reset_regs got %h want 0", {frame_num, ep0_pid}); end
  endtask

  task automatic test_data_ack();
    load(1, 4, 8'h01, 1'b1);
    n_cmp++; if (ep_wr_ready !== 2'b01) begin n_bad++; $display("FAIL ep2_full_ready got %b want 01", ep_wr_ready); end
    send_tok(P_IN, ADDR, 4'd2);
    get_pkt(1'b0);
    n_cmp++; if ({cap_pid, end_pid, got_end} !== {P_DATA0, P_DATA0, 1'b1})
      begin n_bad++; $display("FAIL ep2_pid got %h/%h end=%b want 3/3 end=1", cap_pid, end_pid, got_end); end
    n_cmp++; if (cap_n !== 4 || capv[31:0] !== 32'h01020304)
      begin n_bad++; $display("FAIL ep2_payload got n=%0d %h want n=4 01020304", cap_n, capv[31:0]); end
    n_cmp++; if (st_t !== 1) begin n_bad++; $display("FAIL ep2_start_latency got %0d want 1", st_t); end
    send_raw(P_ACK, 8'h00, 8'h00, 0, 1'b0, 2'b00);
    n_cmp++; if ({ep_sent, ep_wr_ready} !== 4'b1001) begin n_bad++; $display("FAIL ep2_sent got %b want 1001", {ep_sent, ep_wr_ready}); end
    tick();
    n_cmp++; if ({ep_sent, ep_wr_ready} !== 4'b0011) begin n_bad++; $display("FAIL ep2_release got %b want 0011", {ep_sent, ep_wr_ready}); end
    load(1, 1, 8'hAA, 1'b1);
    send_tok(P_IN, ADDR, 4'd2);
    get_pkt(1'b0);
    n_cmp++; if ({cap_pid, capv[7:0]} !== {P_DATA1, 8'hAA} || cap_n !== 1)
      begin n_bad++; $display("FAIL ep2_second got pid=%h n=%0d %h want b n=1 aa", cap_pid, cap_n, capv[7:0]); end
    send_raw(P_ACK, 8'h00, 8'h00, 0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_nak();
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b0);
    n_cmp++; if ({cap_pid, end_pid, got_end} !== {P_NAK, P_NAK, 1'b1} || cap_n !== 0)
      begin n_bad++; $display("FAIL nak got pid=%h n=%0d want a n=0", cap_pid, cap_n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nak_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    load(0, 3, 8'h11, 1'b1);
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b0);
    n_cmp++; if ({cap_pid, capv[23:0]} !== {P_DATA0, 24'h111213} || cap_n !== 3)
      begin n_bad++; $display("FAIL to_first got pid=%h %h want 3 111213", cap_pid, capv[23:0]); end
    w = 0;
    while (busy && w < 300) begin
      tick();
      w++;
    end
    n_cmp++; if (w !== 96) begin n_bad++; $display("FAIL to_wait got %0d cycles want 96", w); end
    n_cmp++; if ({ep_sent, ep_wr_ready[0]} !== 3'b000) begin n_bad++; $display("FAIL to_kept got %b want 000", {ep_sent, ep_wr_ready[0]}); end
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b1);
    n_cmp++; if ({cap_pid, capv[23:0]} !== {P_DATA0, 24'h111213} || cap_n !== 3)
      begin n_bad++; $display("FAIL to_resend got pid=%h %h want 3 111213", cap_pid, capv[23:0]); end
    n_cmp++; if (viol !== 0 || got_end !== 1'b1) begin n_bad++; $display("FAIL to_stall_rules got viol=%0d end=%b want 0 1", viol, got_end); end
    send_raw(P_ACK, 8'h00, 8'h00, 0, 1'b0, 2'b00);
    n_cmp++; if (ep_sent !== 2'b01) begin n_bad++; $display("FAIL to_sent got %b want 01", ep_sent); end
    tick();
  endtask

  task automatic test_halt_toggle_clr();
    load(0, 2, 8'h55, 1'b1);
    ep_halt = 2'b01;
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b0);
    ep_halt = 2'b00;
    n_cmp++; if (cap_pid !== P_STALL || cap_n !== 0) begin n_bad++; $display("FAIL stall got pid=%h n=%0d want e n=0", cap_pid, cap_n); end
    n_cmp++; if (ep_wr_ready[0] !== 1'b0) begin n_bad++; $display("FAIL stall_full got %b want 0", ep_wr_ready[0]); end
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b0);
    n_cmp++; if ({cap_pid, capv[15:0]} !== {P_DATA1, 16'h5556}) begin n_bad++; $display("FAIL halt_release got pid=%h %h want b 5556", cap_pid, capv[15:0]); end
    send_raw(P_ACK, 8'h00, 8'h00, 0, 1'b0, 2'b00);
    tick();
    load(0, 1, 8'h77, 1'b1);
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b0);
    n_cmp++; if ({cap_pid, capv[7:0]} !== {P_DATA0, 8'h77}) begin n_bad++; $display("FAIL pre_clr got pid=%h %h want 3 77", cap_pid, capv[7:0]); end
    send_raw(P_ACK, 8'h00, 8'h00, 0, 1'b0, 2'b01);
    tick();
    load(0, 1, 8'h78, 1'b1);
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b0);
    n_cmp++; if ({cap_pid, capv[7:0]} !== {P_DATA0, 8'h78}) begin n_bad++; $display("FAIL clr_wins got pid=%h %h want 3 78", cap_pid, capv[7:0]); end
    send_raw(P_ACK, 8'h00, 8'h00, 0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_sof_ep0_ignore();
    send_raw(P_SOF, 8'hA3, 8'h05, 2, 1'b0, 2'b00);
    n_cmp++; if ({sof_pulse, frame_num} !== {1'b1, 11'h5A3}) begin n_bad++; $display("FAIL sof got %b %h want 1 5a3", sof_pulse, frame_num); end
    tick();
    n_cmp++; if (sof_pulse !== 1'b0) begin n_bad++; $display("FAIL sof_pulse_width got %b want 0", sof_pulse); end
    load(1, 1, 8'h99, 1'b1);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: send_tok(P_IN, ADDR ^ 7'h01, 4'd2);
        1: send_raw(P_IN, {1'b0, ADDR}, 8'h01, 2, 1'b1, 2'b00);
        2: send_raw(P_IN, {1'b0, ADDR}, 8'h01, 3, 1'b0, 2'b00);
        3: send_tok(P_IN, ADDR, 4'd3);
        default: send_tok(P_OUT, ADDR, 4'd2);
      endcase
      w = 0;
      for (int c = 0; c < 6; c++) begin
        if (pk.tx_pkt_start || ep0_token) w++;
        tick();
      end
      n_cmp++; if (w !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL ignore_%0d got activity=%0d busy=%b want 0 0", k, w, busy); end
    end
    send_tok(P_SETUP, ADDR, 4'd0);
    n_cmp++; if ({ep0_token, ep0_pid} !== {1'b1, P_SETUP}) begin n_bad++; $display("FAIL ep0 got %b %b want 1 1101", ep0_token, ep0_pid); end
    tick();
    n_cmp++; if ({ep0_token, busy, pk.tx_pkt_start} !== 3'b000) begin n_bad++; $display("FAIL ep0_after got %b want 000", {ep0_token, busy, pk.tx_pkt_start}); end
    send_tok(P_IN, ADDR, 4'd2);
    get_pkt(1'b0);
    send_raw(P_ACK, 8'h00, 8'h00, 0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_fill_overflow();
    load(1, 8, 8'hB0, 1'b0);
    n_cmp++; if (ep_wr_ready !== 2'b01) begin n_bad++; $display("FAIL fill_full got %b want 01", ep_wr_ready); end
    load(1, 1, 8'hFF, 1'b1);
    send_tok(P_IN, ADDR, 4'd2);
    get_pkt(1'b0);
    n_cmp++; if (cap_n !== 8 || capv !== 64'hB0B1B2B3B4B5B6B7) begin n_bad++; $display("FAIL fill_payload got n=%0d %h want 8 b0..b7", cap_n, capv); end
    send_raw(P_ACK, 8'h00, 8'h00, 0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_reset_mid();
    load(0, 4, 8'hC0, 1'b1);
    send_tok(P_IN, ADDR, 4'd1);
    tick();
    tick();
    n_cmp++; if (pk.tx_data_valid !== 1'b1) begin n_bad++; $display("FAIL mid_in_data got %b want 1", pk.tx_data_valid); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({busy, pk.tx_data_valid, pk.tx_pkt_end, pk.tx_pkt_start, pk.tx_pid, ep_wr_ready} !== 10'b0000000011)
      begin n_bad++; $display("FAIL mid_reset got %b want 0000000011", {busy, pk.tx_data_valid, pk.tx_pkt_end, pk.tx_pkt_start, pk.tx_pid, ep_wr_ready}); end
    rst = 1'b0;
    tick();
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b0);
    n_cmp++; if (cap_pid !== P_NAK) begin n_bad++; $display("FAIL mid_discard got %h want a", cap_pid); end
    load(0, 1, 8'h42, 1'b1);
    send_tok(P_IN, ADDR, 4'd1);
    get_pkt(1'b0);
    n_cmp++; if ({cap_pid, capv[7:0]} !== {P_DATA0, 8'h42}) begin n_bad++; $display("FAIL mid_toggle got pid=%h %h want 3 42", cap_pid, capv[7:0]); end
  endtask

  initial begin
    rst = 1'b1;
    dev_addr = ADDR;
    pk.rx_pid = 4'd0;
    pk.rx_pid_valid = 1'b0;
    pk.rx_data = 8'd0;
    pk.rx_data_valid = 1'b0;
    pk.rx_pkt_start = 1'b0;
    pk.rx_pkt_end = 1'b0;
    pk.rx_crc_err = 1'b0;
    pk.tx_ready = 1'b1;
    ep_wr_data = '0;
    ep_wr_valid = '0;
    ep_wr_last = '0;
    ep_halt = '0;
    ep_toggle_clr = '0;
    test_reset();
    test_data_ack();
    test_nak();
    test_timeout();
    test_halt_toggle_clr();
    test_sof_ep0_ignore();
    test_fill_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
